mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_pkg.sv | 29 ++
 rtl/sram_1p.sv | 28 ++
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - width encodings, FSM states and port select shared by mem_port_arbiter
package mem_pkg;

    localparam logic [1:0] MW_BYTE = 2'd0;
    localparam logic [1:0] MW_HALF = 2'd1;
    localparam logic [1:0] MW_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        PORT_FE  = 1'b0,
        PORT_MEM = 1'b1
    } port_t;

    // Width 3 is reserved and always treated as a faulting access.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
        case (width)
            MW_BYTE: return 1'b0;
            MW_HALF: return lane[0];
            MW_WORD: return (lane != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sram_1p.sv
// rtl/sram_1p.sv - single-port synchronous RAM, 32-bit words with byte enables
module sram_1p #(
    parameter int DEPTH     = 4096,
    parameter int AW        = 12,
    parameter     INIT_FILE = ""
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data port arbiter in front of a single-port RAM
// Optional wait states are built in when MEM_WAIT_STATES_EN is defined.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fe_req,
    input  logic [31:0] fe_addr,
    output logic        fe_ack,
    output logic [31:0] fe_data,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    input  logic        mem_write,
    input  logic [31:0] mem_data_in,
    input  logic        mem_extend,
    input  logic [1:0]  mem_width,
    output logic        mem_ack,
    output logic [31:0] mem_data_out,
    output logic        mis_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        state;
    port_t         last_grant;
    port_t         cur_port;
    logic [AW-1:0] lat_idx;
    logic [1:0]    lat_lane;
    logic [1:0]    lat_width;
    logic          lat_write;
    logic          lat_extend;
    logic          lat_bad;
    logic [31:0]   lat_wdata;
`ifdef MEM_WAIT_STATES_EN
    localparam logic [15:0] WAIT_LOAD = 16'(WAIT_CYCLES);
    logic [15:0]   wait_cnt;
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

    port_t         grant;
    logic [31:0]   req_addr;
    logic          req_bad;
    logic          unused_addr;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic [15:0]   lane_shift;
    logic [31:0]   load_val;

    always_comb begin
        if (fe_req && mem_req) begin
            grant = (last_grant == PORT_MEM) ? PORT_FE : PORT_MEM;
        end else if (mem_req) begin
            grant = PORT_MEM;
        end else begin
            grant = PORT_FE;
        end
        req_addr = (grant == PORT_MEM) ? mem_addr : fe_addr;
        req_bad  = (grant == PORT_MEM) && is_misaligned(mem_width, mem_addr[1:0]);
    end

    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

    // In IDLE the RAM is addressed straight from the winning request so the
    // synchronous read lands in the response cycle without an extra stage.
    assign ram_addr = (state == ST_IDLE) ? req_addr[AW+1:2] : lat_idx;
    assign ram_we   = (state == ST_RESP) && (cur_port == PORT_MEM) && lat_write && !lat_bad;

    always_comb begin
        ram_be    = 4'b1111;
        ram_wdata = lat_wdata;
        case (lat_width)
            MW_BYTE: begin
                ram_be    = 4'b0001 << lat_lane;
                ram_wdata = {4{lat_wdata[7:0]}};
            end
            MW_HALF: begin
                ram_be    = lat_lane[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{lat_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_shift = 16'(ram_rdata >> {lat_lane, 3'b000});
        case (lat_width)
            MW_BYTE: load_val = {{24{lat_extend & lane_shift[7]}}, lane_shift[7:0]};
            MW_HALF: load_val = {{16{lat_extend & lane_shift[15]}}, lane_shift[15:0]};
            default: load_val = ram_rdata;
        endcase
    end

    assign fe_data      = fe_ack ? ram_rdata : 32'h0;
    assign mem_data_out = (mem_ack && !mis_err && !lat_write) ? load_val : 32'h0;

    sram_1p #(
        .DEPTH     (DEPTH_WORDS),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= PORT_FE;
            cur_port   <= PORT_FE;
            lat_idx    <= '0;
            lat_lane   <= 2'b00;
            lat_width  <= 2'b00;
            lat_write  <= 1'b0;
            lat_extend <= 1'b0;
            lat_bad    <= 1'b0;
            lat_wdata  <= 32'h0;
            fe_ack     <= 1'b0;
            mem_ack    <= 1'b0;
            mis_err    <= 1'b0;
`ifdef MEM_WAIT_STATES_EN
            wait_cnt   <= 16'd0;
`endif
        end else begin
            fe_ack  <= 1'b0;
            mem_ack <= 1'b0;
            mis_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fe_req || mem_req) begin
                        cur_port   <= grant;
                        last_grant <= grant;
                        lat_idx    <= req_addr[AW+1:2];
                        lat_lane   <= mem_addr[1:0];
                        lat_width  <= mem_width;
                        lat_write  <= mem_write;
                        lat_extend <= mem_extend;
                        lat_bad    <= req_bad;
                        lat_wdata  <= mem_data_in;
`ifdef MEM_WAIT_STATES_EN
                        if (WAIT_LOAD != 16'd0) begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= ST_WAIT;
                        end else begin
                            state   <= ST_RESP;
                            fe_ack  <= (grant == PORT_FE);
                            mem_ack <= (grant == PORT_MEM);
                            mis_err <= req_bad;
                        end
`else
                        state   <= ST_RESP;
                        fe_ack  <= (grant == PORT_FE);
                        mem_ack <= (grant == PORT_MEM);
                        mis_err <= req_bad;
`endif
                    end
                end
`ifdef MEM_WAIT_STATES_EN
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 16'd1;
                    if (wait_cnt == 16'd1) begin
                        state   <= ST_RESP;
                        fe_ack  <= (cur_port == PORT_FE);
                        mem_ack <= (cur_port == PORT_MEM);
                        mis_err <= lat_bad;
                    end
                end
`endif
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

`ifdef MEM_WAIT_STATES_EN
    localparam int WAITS = 3;
`else
    localparam int WAITS = 0;
`endif
    localparam int LAT = WAITS + 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fe_req = 1'b0;
    logic [31:0] fe_addr = 32'h0;
    logic        fe_ack;
    logic [31:0] fe_data;
    logic        mem_req = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_data_in = 32'h0;
    logic        mem_extend = 1'b0;
    logic [1:0]  mem_width = 2'd0;
    logic        mem_ack;
    logic [31:0] mem_data_out;
    logic        mis_err;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DEPTH_WORDS (4096),
        .WAIT_CYCLES (3),
        .INIT_FILE   ("")
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fe_req       (fe_req),
        .fe_addr      (fe_addr),
        .fe_ack       (fe_ack),
        .fe_data      (fe_data),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_write    (mem_write),
        .mem_data_in  (mem_data_in),
        .mem_extend   (mem_extend),
        .mem_width    (mem_width),
        .mem_ack      (mem_ack),
        .mem_data_out (mem_data_out),
        .mis_err      (mis_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mem_op(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] width, input logic ext,
                          input logic [31:0] exp_data, input logic exp_err);
        int n;
        @(negedge clk);
        mem_req = 1'b1; mem_write = wr; mem_addr = addr;
        mem_data_in = wdata; mem_width = width; mem_extend = ext;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_ack && n < 50);
        chk({tag, " latency"}, 32'(n), 32'(LAT));
        chk({tag, " mis_err"}, 32'(mis_err), 32'(exp_err));
        chk({tag, " fe_ack"}, 32'(fe_ack), 32'h0);
        if (!wr) chk({tag, " data"}, mem_data_out, exp_data);
        mem_req = 1'b0;
        @(negedge clk);
        chk({tag, " ack pulse"}, 32'(mem_ack), 32'h0);
    endtask

    task automatic fe_op(input string tag, input logic [31:0] addr, input logic [31:0] exp_data);
        int n;
        @(negedge clk);
        fe_req = 1'b1; fe_addr = addr;
        n = 0;
        do begin @(negedge clk); n++; end while (!fe_ack && n < 50);
        chk({tag, " latency"}, 32'(n), 32'(LAT));
        chk({tag, " data"}, fe_data, exp_data);
        chk({tag, " mem_ack"}, 32'(mem_ack), 32'h0);
        fe_req = 1'b0;
        @(negedge clk);
        chk({tag, " ack pulse"}, 32'(fe_ack), 32'h0);
    endtask

    initial begin
        int n;
        @(negedge clk);
        chk("reset fe_ack", 32'(fe_ack), 32'h0);
        chk("reset mem_ack", 32'(mem_ack), 32'h0);
        chk("reset mis_err", 32'(mis_err), 32'h0);
        chk("reset fe_data", fe_data, 32'h0);
        chk("reset mem_data_out", mem_data_out, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        mem_op("st_w 100", 1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0, 1'b0);
        mem_op("ld_w 100", 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
        mem_op("st_b 101", 1'b1, 32'h101, 32'h00000080, 2'd0, 1'b0, 32'h0, 1'b0);
        mem_op("ld_b 101 sx", 1'b0, 32'h101, 32'h0, 2'd0, 1'b1, 32'hFFFFFF80, 1'b0);
        mem_op("ld_b 101 zx", 1'b0, 32'h101, 32'h0, 2'd0, 1'b0, 32'h00000080, 1'b0);
        mem_op("ld_w 100 after byte", 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'hDEAD80EF, 1'b0);
        mem_op("ld_h 102 sx", 1'b0, 32'h102, 32'h0, 2'd1, 1'b1, 32'hFFFFDEAD, 1'b0);
        mem_op("ld_h 100 zx", 1'b0, 32'h100, 32'h0, 2'd1, 1'b0, 32'h000080EF, 1'b0);
        fe_op("fe 103", 32'h103, 32'hDEAD80EF);

        mem_op("st_w 200", 1'b1, 32'h200, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0, 1'b0);
        mem_op("st_h 202", 1'b1, 32'h202, 32'h00001234, 2'd1, 1'b0, 32'h0, 1'b0);
        mem_op("ld_w 200", 1'b0, 32'h200, 32'h0, 2'd2, 1'b0, 32'h1234F00D, 1'b0);
        mem_op("ld_h 203 mis", 1'b0, 32'h203, 32'h0, 2'd1, 1'b1, 32'h0, 1'b1);
        mem_op("st_w 202 mis", 1'b1, 32'h202, 32'h55555555, 2'd2, 1'b0, 32'h0, 1'b1);
        mem_op("ld_w 200 unchanged", 1'b0, 32'h200, 32'h0, 2'd2, 1'b0, 32'h1234F00D, 1'b0);
        mem_op("ld width3", 1'b0, 32'h200, 32'h0, 2'd3, 1'b0, 32'h0, 1'b1);

        mem_op("st_w 0", 1'b1, 32'h0, 32'h0BADC0DE, 2'd2, 1'b0, 32'h0, 1'b0);
        mem_op("ld_w 4000 wrap", 1'b0, 32'h4000, 32'h0, 2'd2, 1'b0, 32'h0BADC0DE, 1'b0);
        mem_op("st_b 4003 wrap", 1'b1, 32'h4003, 32'h000000A5, 2'd0, 1'b0, 32'h0, 1'b0);
        fe_op("fe 0 after wrap store", 32'h0, 32'hA5ADC0DE);

        // Reset landing in the response cycle of a store must suppress the write.
        mem_op("st_w 300", 1'b1, 32'h300, 32'h11111111, 2'd2, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        mem_req = 1'b1; mem_write = 1'b1; mem_addr = 32'h300;
        mem_data_in = 32'h22222222; mem_width = 2'd2;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_ack && n < 50);
        chk("rst_resp latency", 32'(n), 32'(LAT));
        reset_n = 1'b0;
        mem_req = 1'b0; mem_write = 1'b0;
        #1;
        chk("rst_resp ack dropped", 32'(mem_ack), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mem_op("ld_w 300 after reset", 1'b0, 32'h300, 32'h0, 2'd2, 1'b0, 32'h11111111, 1'b0);

        // Fresh reset so the arbiter starts from last-grant = fetch.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        fe_req = 1'b1; fe_addr = 32'h100;
        mem_req = 1'b1; mem_write = 1'b0; mem_addr = 32'h200; mem_width = 2'd2; mem_extend = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!(fe_ack || mem_ack) && n < 50);
            chk($sformatf("arb%0d latency", k), 32'(n), (k == 0) ? 32'(LAT) : 32'(LAT + 1));
            chk($sformatf("arb%0d grant", k), 32'({fe_ack, mem_ack}), (k == 1) ? 32'h2 : 32'h1);
            chk($sformatf("arb%0d fe_data", k), fe_data, (k == 1) ? 32'hDEAD80EF : 32'h0);
            chk($sformatf("arb%0d mem_data_out", k), mem_data_out, (k == 1) ? 32'h0 : 32'h1234F00D);
        end
        fe_req = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        chk("arb end acks", 32'({fe_ack, mem_ack}), 32'h0);

`ifdef MEM_WAIT_STATES_EN
        @(negedge clk);
        fe_req = 1'b1; fe_addr = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("wait no early ack", 32'(fe_ack), 32'h0);
        reset_n = 1'b0;
        fe_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("wait reset no ack %0d", k), 32'({fe_ack, mem_ack}), 32'h0);
        end
        reset_n = 1'b1;
        fe_op("fe 0 after wait reset", 32'h0, 32'hA5ADC0DE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
